lfsr_rng_arbiter: RTL

Shares one 32-bit Fibonacci LFSR random source between `N_REQ` requesters. Each grant delivers one random word, and the LFSR advances only when a word is consumed. A fair round-robin arbiter picks one requester per cycle. A seed-load path reseeds the generator, then steps it through a fixed warm-up before it serves requests again. The block sits between the shared PRNG datapath and the stimulus/scrambler clients that draw words from it.

---
 rtl/lfsr_rng_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Shared 32-bit Fibonacci LFSR source with round-robin arbitration between requesters.
// A seed load reseeds the generator and runs a fixed warm-up before serving again.
module lfsr_rng_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter logic [31:0] SEED   = 32'h0000_0001,
    parameter int unsigned WARMUP = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rand_valid,
    output logic [31:0]      rand_data,
    input  logic             seed_load,
    input  logic [31:0]      seed_val,
    output logic             busy,
    output logic             seed_err
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] WARM_END = CNT_W'(WARMUP);

    typedef enum logic {ST_RUN, ST_WARMUP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [31:0]        lfsr_step;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               rand_valid_q, rand_valid_d;
    logic [31:0]        rand_data_q, rand_data_d;
    logic               busy_q, busy_d;
    logic               seed_err_q, seed_err_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    assign lfsr_step = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[29] ^ lfsr_q[25] ^ lfsr_q[24]};

    // Round-robin pick: first set request searching upward from last+1 with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(last_q) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and output logic; a seed load pre-empts both serving and warm-up.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        rand_valid_d = 1'b0;
        rand_data_d  = rand_data_q;
        seed_err_d   = 1'b0;

        if (seed_load) begin
            lfsr_d     = (seed_val == 32'd0) ? SEED : seed_val;
            seed_err_d = (seed_val == 32'd0);
            cnt_d      = '0;
            state_d    = ST_WARMUP;
        end else if (state_q == ST_WARMUP) begin
            lfsr_d = lfsr_step;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_d == WARM_END) begin
                state_d = ST_RUN;
            end
        end else if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            rand_valid_d   = 1'b1;
            rand_data_d    = lfsr_q;
            lfsr_d         = lfsr_step;
            last_d         = win_idx;
        end

        busy_d = (state_d == ST_WARMUP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            lfsr_q       <= SEED;
            last_q       <= LAST_RST;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rand_valid_q <= 1'b0;
            rand_data_q  <= 32'd0;
            busy_q       <= 1'b0;
            seed_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            rand_valid_q <= rand_valid_d;
            rand_data_q  <= rand_data_d;
            busy_q       <= busy_d;
            seed_err_q   <= seed_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign rand_valid = rand_valid_q;
    assign rand_data  = rand_data_q;
    assign busy       = busy_q;
    assign seed_err   = seed_err_q;

endmodule
